// File: rtl/bcd_serial_subtractor_if.sv
// ============================================================================
// Module  : bcd_serial_subtractor_if
// Brief   : Request/result bundle for the digit-serial BCD subtractor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_serial_subtractor_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  neg;
  logic                  invalid;

  modport master (
    output start, a, b,
    input  busy, done, diff, neg, invalid
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, neg, invalid
  );
endinterface

`default_nettype wire

// File: rtl/bcd_serial_subtractor.sv
// ============================================================================
// Module  : bcd_serial_subtractor
// Brief   : Digit-serial BCD A-B, LSD first, registered decimal borrow.
//           Define BCD_SUB_SIGNMAG_EN to return sign/magnitude instead of
//           10's complement for negative results.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bcd_serial_subtractor_if.slave   bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

`ifdef BCD_SUB_SIGNMAG_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    COMP = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t                  state;
  state_t                  state_next;
  logic [DIGITS-1:0][3:0]  a_q;
  logic [DIGITS-1:0][3:0]  b_q;
  logic [DIGITS-1:0][3:0]  diff_q;
  logic [IDX_W-1:0]        idx;
  logic                    borrow;
  logic                    neg_q;
  logic                    invalid_q;

  logic                    ops_bad;
  logic                    last_digit;
  logic                    in_comp;
  logic [3:0]              min_d;
  logic [3:0]              sub_d;
  logic [4:0]              t;
  logic [3:0]              d;
  logic                    busy_w;
  logic                    done_w;

  assign last_digit = (idx == LAST_IDX);

`ifdef BCD_SUB_SIGNMAG_EN
  assign in_comp = (state == COMP);
`else
  assign in_comp = 1'b0;
`endif

  always_comb begin
    ops_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_q[i] > 4'd9 || b_q[i] > 4'd9) ops_bad = 1'b1;
    end
  end

  // Shared digit engine: in COMP the minuend is zero and the subtrahend is
  // the 10's complement left in diff, which yields the magnitude.
  always_comb begin
    min_d = in_comp ? 4'd0 : a_q[idx];
    sub_d = in_comp ? diff_q[idx] : b_q[idx];
    t     = {1'b0, min_d} - {1'b0, sub_d} - {4'd0, borrow};
    d     = t[4] ? (t[3:0] + 4'd10) : t[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_w     = (state != IDLE);
    done_w     = 1'b0;
    case (state)
      IDLE: if (bus.start) state_next = SUB;
      SUB: begin
        if (ops_bad) begin
          state_next = DONE;
        end else if (last_digit) begin
`ifdef BCD_SUB_SIGNMAG_EN
          state_next = t[4] ? COMP : DONE;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef BCD_SUB_SIGNMAG_EN
      COMP: if (last_digit) state_next = DONE;
`endif
      DONE: begin
        done_w     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      diff_q    <= '0;
      idx       <= '0;
      borrow    <= 1'b0;
      neg_q     <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q       <= bus.a;
            b_q       <= bus.b;
            diff_q    <= '0;
            idx       <= '0;
            borrow    <= 1'b0;
            neg_q     <= 1'b0;
            invalid_q <= 1'b0;
          end
        end
        SUB: begin
          if (ops_bad) begin
            invalid_q <= 1'b1;
            diff_q    <= '0;
            neg_q     <= 1'b0;
          end else begin
            diff_q[idx] <= d;
            if (last_digit) begin
              neg_q  <= t[4];
              idx    <= '0;
              borrow <= 1'b0;
            end else begin
              borrow <= t[4];
              idx    <= idx + 1'b1;
            end
          end
        end
`ifdef BCD_SUB_SIGNMAG_EN
        COMP: begin
          diff_q[idx] <= d;
          if (last_digit) begin
            idx    <= '0;
            borrow <= 1'b0;
          end else begin
            borrow <= t[4];
            idx    <= idx + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_w;
  assign bus.done    = done_w;
  assign bus.diff    = diff_q;
  assign bus.neg     = neg_q;
  assign bus.invalid = invalid_q;

endmodule

`default_nettype wire
